// File: rtl/attn_value_mix.sv
// Attention value mixer: weighted sum of four Q0.7 value rows by UQ0.8 weights, streamed out as Q0.7.
// Build option ATTN_MIX_ROUND_EN selects round-half-up before the output shift (default truncates).
module attn_value_mix #(
    parameter int N_FEAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_data_i,
    input  logic       s_vld_i,
    output logic       s_rdy_o,
    output logic [7:0] m_data_o,
    output logic       m_vld_o,
    input  logic       m_rdy_i,
    output logic       m_last_o
);

    localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
`ifdef ATTN_MIX_ROUND_EN
    localparam logic signed [18:0] RND = 19'sd128;
`else
    localparam logic signed [18:0] RND = 19'sd0;
`endif

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_V = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [1:0]               k_q;
    logic [FW-1:0]            f_q;
    logic [7:0]               w_q   [4];
    logic signed [18:0]       acc_q [N_FEAT];
    logic                     s_rdy_q;
    logic                     m_vld_q;
    logic [7:0]               m_data_q;
    logic                     m_last_q;

    logic signed [16:0]       prod;
    logic signed [18:0]       acc_sum_d;
    logic [FW-1:0]            f_nxt;
    logic                     f_last;

    function automatic logic [7:0] quant(input logic signed [18:0] a);
        logic signed [18:0] s;
        s = (a + RND) >>> 8;
        if (s > 19'sd127)
            return 8'h7F;
        else if (s < -19'sd128)
            return 8'h80;
        else
            return s[7:0];
    endfunction

    assign prod      = $signed({1'b0, w_q[k_q]}) * $signed(s_data_i);
    assign acc_sum_d = acc_q[f_q] + 19'(prod);
    assign f_nxt     = f_q + FW'(1);
    assign f_last    = (f_q == FW'(N_FEAT - 1));

    // Outputs are registered and updated alongside the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= LOAD_W;
            k_q      <= '0;
            f_q      <= '0;
            s_rdy_q  <= 1'b1;
            m_vld_q  <= 1'b0;
            m_data_q <= 8'h00;
            m_last_q <= 1'b0;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
            for (int i = 0; i < N_FEAT; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                LOAD_W: begin
                    if (s_vld_i) begin
                        w_q[k_q] <= s_data_i;
                        k_q      <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            k_q     <= '0;
                            f_q     <= '0;
                            state_q <= LOAD_V;
                            for (int i = 0; i < N_FEAT; i++) acc_q[i] <= '0;
                        end
                    end
                end
                LOAD_V: begin
                    if (s_vld_i) begin
                        acc_q[f_q] <= acc_sum_d;
                        if (f_last) begin
                            f_q <= '0;
                            if (k_q == 2'd3) begin
                                // Last value beat: present feature 0, which for N_FEAT=1 is the sum just formed.
                                state_q  <= DRAIN;
                                s_rdy_q  <= 1'b0;
                                m_vld_q  <= 1'b1;
                                m_data_q <= quant((N_FEAT == 1) ? acc_sum_d : acc_q[0]);
                                m_last_q <= (N_FEAT == 1);
                            end else begin
                                k_q <= k_q + 2'd1;
                            end
                        end else begin
                            f_q <= f_nxt;
                        end
                    end
                end
                DRAIN: begin
                    if (m_rdy_i) begin
                        if (f_last) begin
                            state_q  <= LOAD_W;
                            k_q      <= '0;
                            f_q      <= '0;
                            s_rdy_q  <= 1'b1;
                            m_vld_q  <= 1'b0;
                            m_data_q <= 8'h00;
                            m_last_q <= 1'b0;
                        end else begin
                            f_q      <= f_nxt;
                            m_data_q <= quant(acc_q[f_nxt]);
                            m_last_q <= (f_nxt == FW'(N_FEAT - 1));
                        end
                    end
                end
                default: begin
                    state_q  <= LOAD_W;
                    k_q      <= '0;
                    f_q      <= '0;
                    s_rdy_q  <= 1'b1;
                    m_vld_q  <= 1'b0;
                    m_data_q <= 8'h00;
                    m_last_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_rdy_o  = s_rdy_q;
    assign m_vld_o  = m_vld_q;
    assign m_data_o = m_data_q;
    assign m_last_o = m_last_q;

endmodule

// File: tb/tb_attn_value_mix.sv
// Directed bench for attn_value_mix: an N_FEAT=4 and an N_FEAT=1 instance share one stimulus driver.
module tb_attn_value_mix;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_vld;
    logic       m_rdy;
    logic       sel;

    logic       s_rdy4, m_vld4, m_last4;
    logic [7:0] m_data4;
    logic       s_rdy1, m_vld1, m_last1;
    logic [7:0] m_data1;

    logic       s_rdy_c, m_vld_c, m_last_c;
    logic [7:0] m_data_c;

    int n_vec = 0;
    int n_err = 0;
    int n_cur = 4;

    logic [7:0] w_v [4];
    logic [7:0] v_v [16];
    logic [7:0] e_v [4];

    always #5 clk = ~clk;

    attn_value_mix #(.N_FEAT(4)) u_dut4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_data_i (s_data),
        .s_vld_i  (s_vld & ~sel),
        .s_rdy_o  (s_rdy4),
        .m_data_o (m_data4),
        .m_vld_o  (m_vld4),
        .m_rdy_i  (m_rdy & ~sel),
        .m_last_o (m_last4)
    );

    attn_value_mix #(.N_FEAT(1)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_data_i (s_data),
        .s_vld_i  (s_vld & sel),
        .s_rdy_o  (s_rdy1),
        .m_data_o (m_data1),
        .m_vld_o  (m_vld1),
        .m_rdy_i  (m_rdy & sel),
        .m_last_o (m_last1)
    );

    assign s_rdy_c  = sel ? s_rdy1  : s_rdy4;
    assign m_vld_c  = sel ? m_vld1  : m_vld4;
    assign m_data_c = sel ? m_data1 : m_data4;
    assign m_last_c = sel ? m_last1 : m_last4;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, output int waited);
        waited = 0;
        s_data = d;
        s_vld  = 1'b1;
        while (!s_rdy_c && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) check_val("s_rdy_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_vld  = 1'b0;
        s_data = 8'h00;
    endtask

    task automatic send_frame(input bit bubbles, input bit b2b);
        int w;
        for (int i = 0; i < 4; i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send_beat(w_v[i], w);
            if (b2b && i == 0) check_val("b2b_accept", 32'(w), 32'd0);
        end
        for (int i = 0; i < 4 * n_cur; i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send_beat(v_v[i], w);
        end
    endtask

    task automatic recv_frame(input string tag, input int stall_beat);
        int t;
        for (int f = 0; f < n_cur; f++) begin
            t = 0;
            while (!m_vld_c && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) check_val({tag, "_vld_timeout"}, 32'd0, 32'd1);
            check_val({tag, "_data"}, 32'(m_data_c), 32'(e_v[f]));
            check_val({tag, "_last"}, 32'(m_last_c), (f == n_cur - 1) ? 32'd1 : 32'd0);
            check_val({tag, "_s_rdy_drain"}, 32'(s_rdy_c), 32'd0);
            if (f == stall_beat) begin
                m_rdy = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check_val({tag, "_stall_data"}, 32'(m_data_c), 32'(e_v[f]));
                    check_val({tag, "_stall_vld"}, 32'(m_vld_c), 32'd1);
                    check_val({tag, "_stall_s_rdy"}, 32'(s_rdy_c), 32'd0);
                end
            end
            m_rdy = 1'b1;
            @(posedge clk); #1;
            m_rdy = 1'b0;
        end
        check_val({tag, "_s_rdy_after"}, 32'(s_rdy_c), 32'd1);
        check_val({tag, "_m_vld_after"}, 32'(m_vld_c), 32'd0);
    endtask

    task automatic set_uniform();
        for (int i = 0; i < 4; i++) w_v[i] = 8'h40;
        for (int i = 0; i < 16; i++) v_v[i] = 8'h40;
        for (int i = 0; i < 4; i++) e_v[i] = 8'h40;
    endtask

    initial begin
        int w;
        rst    = 1'b1;
        sel    = 1'b0;
        s_vld  = 1'b0;
        s_data = 8'h00;
        m_rdy  = 1'b0;
        #12;
        check_val("rst_s_rdy", 32'(s_rdy_c), 32'd1);
        check_val("rst_m_vld", 32'(m_vld_c), 32'd0);
        check_val("rst_m_data", 32'(m_data_c), 32'd0);
        check_val("rst_m_last", 32'(m_last_c), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_uniform();
        send_frame(1'b0, 1'b0);
        check_val("uni_latency", 32'(m_vld_c), 32'd1);
        recv_frame("uni", -1);

        w_v[0] = 8'hFF; w_v[1] = 8'h00; w_v[2] = 8'h00; w_v[3] = 8'h00;
        v_v[0] = 8'h7F; v_v[1] = 8'h80; v_v[2] = 8'h01; v_v[3] = 8'h00;
        for (int i = 4; i < 16; i++) v_v[i] = 8'($urandom);
`ifdef ATTN_MIX_ROUND_EN
        e_v[0] = 8'h7F; e_v[1] = 8'h81; e_v[2] = 8'h01; e_v[3] = 8'h00;
`else
        e_v[0] = 8'h7E; e_v[1] = 8'h80; e_v[2] = 8'h00; e_v[3] = 8'h00;
`endif
        send_frame(1'b0, 1'b0);
        recv_frame("onehot", -1);

        for (int i = 0; i < 4; i++) w_v[i] = 8'hFF;
        for (int i = 0; i < 16; i++) v_v[i] = 8'h7F;
        for (int i = 0; i < 4; i++) e_v[i] = 8'h7F;
        send_frame(1'b0, 1'b0);
        recv_frame("sat_pos", -1);

        for (int i = 0; i < 16; i++) v_v[i] = 8'h80;
        for (int i = 0; i < 4; i++) e_v[i] = 8'h80;
        send_frame(1'b0, 1'b0);
        recv_frame("sat_neg", -1);

        set_uniform();
        send_frame(1'b1, 1'b0);
        check_val("hs_latency", 32'(m_vld_c), 32'd1);
        recv_frame("hs", 2);
        send_frame(1'b0, 1'b1);
        recv_frame("b2b", -1);

        set_uniform();
        for (int i = 0; i < 4; i++) send_beat(w_v[i], w);
        for (int i = 0; i < 6; i++) send_beat(v_v[i], w);
        rst = 1'b1;
        #1;
        check_val("midrst_m_vld", 32'(m_vld_c), 32'd0);
        check_val("midrst_s_rdy", 32'(s_rdy_c), 32'd1);
        @(posedge clk); #1;
        check_val("midrst_m_vld_hold", 32'(m_vld_c), 32'd0);
        check_val("midrst_s_rdy_hold", 32'(s_rdy_c), 32'd1);
        rst = 1'b0;
        send_frame(1'b0, 1'b0);
        recv_frame("postrst", -1);
        m_rdy = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_val("postrst_no_stale", 32'(m_vld_c), 32'd0);
        end
        m_rdy = 1'b0;

        sel   = 1'b1;
        n_cur = 1;
        w_v[0] = 8'h80; w_v[1] = 8'h80; w_v[2] = 8'h00; w_v[3] = 8'h00;
        v_v[0] = 8'h40; v_v[1] = 8'hC0; v_v[2] = 8'h7F; v_v[3] = 8'h7F;
        e_v[0] = 8'h00;
        send_frame(1'b0, 1'b0);
        check_val("n1_latency", 32'(m_vld_c), 32'd1);
        recv_frame("n1", -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/attn_value_mix.md
# attn_value_mix

Downstream stage of the attention datapath: consumes the four UQ0.8 softmax weights produced by the score/normalise stage, then a 4×N_FEAT block of Q0.7 value elements. It computes the weighted sum out[f] = Σ_i w[i]·v[i][f] for each feature f, and streams the N_FEAT results as Q0.7 bytes on a valid/ready master port. Both ports use the same 8-bit vld/rdy handshake as the rest of the engine. One frame is processed at a time; there is no overlap between input and output of a frame.

## Interface
- N_FEAT, default 4: features per value row, which is also the number of output beats per frame. Legal range 1..8.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  input stream: 4 weights (UQ0.8), then values (Q0.7, two's complement).
- s_vld  in  1  input beat valid.
- s_rdy  out  1  input ready.
- m_data  out  8  output element, Q0.7.
- m_vld  out  1  output beat valid.
- m_rdy  in  1  downstream ready.
- m_last  out  1  high with the final output beat of a frame (f = N_FEAT−1).

## Operation
- Frame order on the input: w[0], w[1], w[2], w[3], then v[0][0..N_FEAT−1], v[1][0..], v[2][0..], v[3][0..] (row-major, key index outer).
- A beat transfers on a rising edge where vld & rdy. Cycles with s_vld low are bubbles and change no state.
- State machine, with reset state LOAD_W:
  - LOAD_W: s_rdy=1. Each accepted beat stores w[k_idx], and k_idx increments. After w[3] is accepted: k_idx←0, f_idx←0, all accumulators←0, and the state moves to LOAD_V.
  - LOAD_V: s_rdy=1. Each accepted beat does acc[f_idx] += $signed({1'b0,w[k_idx]}) · $signed(v).
    - f_idx wraps at N_FEAT−1; on each wrap, k_idx increments.
    - Accepting v[3][N_FEAT−1] moves the state to DRAIN with f_idx←0.
  - DRAIN: s_rdy=0, m_vld=1, m_data=q(acc[f_idx]), m_last=(f_idx==N_FEAT−1).
    - On m_vld & m_rdy, f_idx increments.
    - If the transfer is the last beat, the state moves to LOAD_W with k_idx←0.
- Arithmetic:
  - Each product is 9b×8b signed, giving a 17-bit Q1.15 value.
  - Accumulators are 19-bit signed; the worst case is ±4·255·128, which fits without wrap.
  - q(a) = saturate_s8((a + RND) >>> 8), where RND is set by the configuration macro.
  - Saturation clamps to the range [−128, 127] (0x80 to 0x7F).
- Weights are not required to sum to 1.0; saturation covers any overshoot.
- Outputs when not in DRAIN: m_vld=0, m_data=0x00, m_last=0.

## Timing
- Reset values: s_rdy=1 (state LOAD_W), m_vld=0, m_data=0x00, m_last=0. All counters, weights and accumulators are cleared.
- Reset mid-frame: the partial frame is discarded immediately (asynchronously) with no output. The next frame starts from w[0].
- s_rdy, m_vld, m_data and m_last are decoded from registered state only. There is no combinational path from s_vld or m_rdy to any output.
- Latency: m_vld rises in the cycle after the edge that accepts v[3][N_FEAT−1].
- Backpressure: while m_vld=1 and m_rdy=0, m_data and m_last hold stable.
- Back-to-back frames: s_rdy rises in the cycle after the last output transfer. w[0] of the next frame can be accepted on the next edge.
- A frame costs at least 4 + 4·N_FEAT input cycles plus N_FEAT output cycles.
- The state never changes without a handshake, except on reset.

## Configuration
- ATTN_MIX_ROUND_EN defined: RND = 128, i.e. round-half-up before the shift, then saturate.
- ATTN_MIX_ROUND_EN undefined: RND = 0, i.e. truncation toward −∞ (arithmetic shift), then saturate.
- All other behaviour is identical in both builds.

## Test plan
- Uniform case: weights 0x40×4, all values 0x40 → four outputs of 0x40, m_last on the 4th beat only. Applies to both builds.
- One-hot case: weights FF,00,00,00 with v[0] = 7F,80,01,00 and other rows random.
  - ROUND_EN build → 7F, 81, 01, 00.
  - Truncating build → 7E, 80, 00, 00.
- Saturation: weights FF×4.
  - Values all 7F → all outputs 0x7F.
  - Values all 80 → all outputs 0x80.
- Handshake: random s_vld bubbles, and m_rdy held low for 5 cycles on beat 2.
  - m_data holds stable while m_rdy is low; s_rdy=0 throughout DRAIN.
  - Results match the uniform case.
  - A second frame sent back-to-back is accepted the cycle after m_last transfers.
- Reset mid-frame: assert rst after 6 value beats.
  - m_vld=0 and s_rdy=1 during reset.
  - The following full frame (uniform vectors) produces exactly four 0x40 beats, with no stale outputs.
- N_FEAT=1 instance: weights 80,80,00,00 and values 40,C0,7F,7F → single beat 0x00 with m_last=1.
